// File: rtl/or_stim_pkg.sv
// Shared types and widths for the OR-gate stimulus sequencer.
package or_stim_pkg;

  localparam int PATTERN_W    = 4;
  localparam int NUM_PATTERNS = 16;
  localparam int HOLD_W       = 8;
  localparam int PASS_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/or_stim_hold_timer.sv
// Per-pattern hold counter: counts 0..HOLD_CYCLES-1, frozen while disabled,
// forced to zero while cleared. o_tc marks the last hold cycle.
module or_stim_hold_timer
  import or_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [HOLD_W-1:0] TC_VAL = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_cnt;

  assign o_tc = (r_cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/or_gate_stimulus_sequencer.sv
// Sweeps all 16 a/b/c/d patterns for a four-input OR gate, NUM_PASSES times per start.
// Define OR_STIM_GRAY_ORDER_EN to drive the patterns in Gray order instead of binary.
module or_gate_stimulus_sequencer
  import or_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_PASSES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pause,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic [PATTERN_W-1:0] pattern_idx,
  output logic                 sample,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam logic [PATTERN_W-1:0] LAST_IDX  = PATTERN_W'(NUM_PATTERNS - 1);
  localparam logic [PASS_W-1:0]    LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_t               r_state, w_state_nxt;
  logic [PATTERN_W-1:0] r_idx, w_idx_nxt;
  logic [PASS_W-1:0]    r_pass, w_pass_nxt;
  logic                 w_adv;
  logic                 w_tc;
  logic                 w_clr;
  logic [PATTERN_W-1:0] w_pat;

  // start is a level, sampled only in IDLE; pause freezes every DRIVE-state register.
  assign w_adv = (r_state == DRIVE) && !pause;
  assign w_clr = (r_state != DRIVE);

  or_stim_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(w_clr),
    .i_en (w_adv),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pass  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pass_nxt  = r_pass;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DRIVE;
          w_idx_nxt   = '0;
          w_pass_nxt  = '0;
        end
      end
      DRIVE: begin
        if (w_adv && w_tc) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (r_pass == LAST_PASS) begin
              w_state_nxt = DONE;
            end else begin
              w_pass_nxt = r_pass + 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_pass_nxt  = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_pass_nxt  = '0;
      end
    endcase
  end

`ifdef OR_STIM_GRAY_ORDER_EN
  assign w_pat = r_idx ^ (r_idx >> 1);
`else
  assign w_pat = r_idx;
`endif

  assign {a, b, c, d} = w_pat;
  assign pattern_idx  = r_idx;
  assign sample       = w_adv && w_tc;
  assign busy         = (r_state == DRIVE);
  assign done         = (r_state == DONE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_or_gate_stimulus_sequencer.sv
// Bench for or_gate_stimulus_sequencer: three instances (H/P = 4/1, 2/2, 1/1) run in lockstep
// against an elapsed-drive-cycle model, plus directed literal checks per scenario.
module tb_or_gate_stimulus_sequencer;

  localparam int NI = 3;
  localparam int HV [NI] = '{4, 2, 1};
  localparam int PV [NI] = '{1, 2, 1};

  localparam logic [3:0] GRAY_TAB [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

`ifdef OR_STIM_GRAY_ORDER_EN
  localparam logic [3:0] L_I2_C3  = 4'b0010;
  localparam logic [3:0] L_I0_P5  = 4'b0111;
  localparam logic [3:0] L_I0_P15 = 4'b1000;
`else
  localparam logic [3:0] L_I2_C3  = 4'b0011;
  localparam logic [3:0] L_I0_P5  = 4'b0101;
  localparam logic [3:0] L_I0_P15 = 4'b1111;
`endif

  // clock / reset / inputs
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [3:0] w_abcd   [NI];
  wire [3:0] w_idx    [NI];
  wire       w_sample [NI];
  wire       w_busy   [NI];
  wire       w_done   [NI];
  wire [1:0] w_dbg    [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    or_gate_stimulus_sequencer #(
      .HOLD_CYCLES(HV[gi]),
      .NUM_PASSES (PV[gi])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pause      (pause),
      .a          (w_abcd[gi][3]),
      .b          (w_abcd[gi][2]),
      .c          (w_abcd[gi][1]),
      .d          (w_abcd[gi][0]),
      .pattern_idx(w_idx[gi]),
      .sample     (w_sample[gi]),
      .busy       (w_busy[gi]),
      .done       (w_done[gi]),
      .dbg_state  (w_dbg[gi])
    );
  end

  // Model: a run is just a count of non-paused drive cycles; everything else is arithmetic on it.
  int   m_t    [NI];
  logic m_run  [NI];
  logic m_done [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_t[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] <= 1'b0;
        if (m_run[i]) begin
          if (!pause) begin
            if (m_t[i] + 1 == 16 * HV[i] * PV[i]) begin
              m_run[i]  <= 1'b0;
              m_done[i] <= 1'b1;
            end else begin
              m_t[i] <= m_t[i] + 1;
            end
          end
        end else if (!m_done[i] && start) begin
          m_run[i] <= 1'b1;
          m_t[i]   <= 0;
        end
      end
    end
  end

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;
  int sample_tot [NI];
  int done_tot   [NI];
  int last_done  [NI];
  int snap_s     [NI];
  int snap_d     [NI];

  function automatic logic [3:0] map_pat(input int k);
`ifdef OR_STIM_GRAY_ORDER_EN
    return GRAY_TAB[k];
`else
    return 4'(k);
`endif
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d t=%0t actual=%0d expected=%0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    int k;
    logic [3:0] prev_abcd [NI];
    logic       prev_busy [NI];
    logic       prev_pause;
    for (int i = 0; i < NI; i++) begin
      prev_abcd[i] = 4'd0;
      prev_busy[i] = 1'b0;
      sample_tot[i] = 0;
      done_tot[i] = 0;
      last_done[i] = 0;
    end
    prev_pause = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        k = m_run[i] ? (m_t[i] / HV[i]) % 16 : 0;
        chk("abcd", i, 32'(w_abcd[i]), 32'(map_pat(k)));
        chk("pattern_idx", i, 32'(w_idx[i]), 32'(k));
        chk("sample", i, 32'(w_sample[i]), 32'(m_run[i] && (m_t[i] % HV[i] == HV[i] - 1) && !pause));
        chk("busy", i, 32'(w_busy[i]), 32'(m_run[i]));
        chk("done", i, 32'(w_done[i]), 32'(m_done[i]));
`ifdef OR_STIM_GRAY_ORDER_EN
        if (i == 2 && w_busy[i] && prev_busy[i] && !prev_pause)
          chk("gray_step", i, 32'($countones(w_abcd[i] ^ prev_abcd[i])), 32'd1);
`endif
        if (w_sample[i] === 1'b1) sample_tot[i]++;
        if (w_done[i] === 1'b1) begin
          done_tot[i]++;
          last_done[i] = cyc;
        end
        prev_abcd[i] = w_abcd[i];
        prev_busy[i] = w_busy[i];
      end
      prev_pause = pause;
    end
  endtask

  // driver tasks
  task automatic start_run();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < NI; i++) begin
      snap_s[i] = sample_tot[i];
      snap_d[i] = done_tot[i];
    end
  endtask

  task automatic wait_rel(input int r);
    int g;
    g = 0;
    while ((cyc - start_cyc) < r) begin
      @(posedge clk);
      #1;
      g++;
      if (g > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_rel timeout actual=%0d required=%0d", cyc - start_cyc, r);
        return;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while ((w_busy[0] | w_busy[1] | w_busy[2] | w_done[0] | w_done[1] | w_done[2]) && g < limit);
    n_tests++;
    if (g >= limit) begin
      n_fail++;
      $display("FAIL idle_timeout actual=%0d cycles required<%0d", g, limit);
    end
  endtask

  task automatic check_run(input int d0, input int d1, input int d2,
                           input int s0, input int s1, input int s2, input int n2);
    int exp_d [NI];
    int exp_s [NI];
    exp_d = '{d0, d1, d2};
    exp_s = '{s0, s1, s2};
    for (int i = 0; i < NI; i++) begin
      chk("done_cycle", i, 32'(last_done[i] - start_cyc), 32'(exp_d[i]));
      chk("sample_count", i, 32'(sample_tot[i] - snap_s[i]), 32'(exp_s[i]));
      chk("done_count", i, 32'(done_tot[i] - snap_d[i]), 32'((i == 2) ? n2 : 1));
    end
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_abcd", i, 32'(w_abcd[i]), 32'd0);
      chk("rst_idx", i, 32'(w_idx[i]), 32'd0);
      chk("rst_busy", i, 32'(w_busy[i]), 32'd0);
      chk("rst_done", i, 32'(w_done[i]), 32'd0);
      chk("rst_state", i, 32'(w_dbg[i]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // A: plain sweep
    start_run();
    chk("a_c0_abcd", 0, 32'(w_abcd[0]), 32'd0);
    chk("a_c0_busy", 0, 32'(w_busy[0]), 32'd1);
    wait_rel(3);
    chk("a_c3_sample", 0, 32'(w_sample[0]), 32'd1);
    chk("a_c3_abcd", 2, 32'(w_abcd[2]), 32'(L_I2_C3));
    chk("a_c3_idx", 2, 32'(w_idx[2]), 32'd3);
    wait_rel(5);
    chk("a_c5_abcd", 0, 32'(w_abcd[0]), 32'b0001);
    wait_rel(31);
    chk("a_c31_idx", 1, 32'(w_idx[1]), 32'd15);
    wait_rel(32);
    chk("a_c32_idx", 1, 32'(w_idx[1]), 32'd0);
    chk("a_c32_busy", 1, 32'(w_busy[1]), 32'd1);
    wait_rel(60);
    chk("a_c60_abcd", 0, 32'(w_abcd[0]), 32'(L_I0_P15));
    wait_idle(300);
    check_run(64, 64, 16, 16, 32, 16, 1);

    // B: 10-cycle pause during pattern 5 of the H=4 instance
    start_run();
    wait_rel(21);
    pause = 1'b1;
    wait_rel(30);
    chk("b_hold_abcd", 0, 32'(w_abcd[0]), 32'(L_I0_P5));
    chk("b_hold_sample", 0, 32'(w_sample[0]), 32'd0);
    chk("b_hold_busy", 0, 32'(w_busy[0]), 32'd1);
    wait_rel(31);
    pause = 1'b0;
    wait_idle(300);
    check_run(74, 74, 16, 16, 32, 16, 1);

    // C: start in DONE (inst2, cycle 16) ignored; start in DRIVE (cycle 20) ignored by inst0/1,
    // accepted by the now-idle inst2
    start_run();
    wait_rel(16);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_rel(20);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(300);
    check_run(64, 64, 37, 16, 32, 32, 2);

    // D: async reset mid-run, then a fresh run
    start_run();
    wait_rel(30);
    chk("d_busy_pre", 0, 32'(w_busy[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("d_rst_abcd", i, 32'(w_abcd[i]), 32'd0);
      chk("d_rst_idx", i, 32'(w_idx[i]), 32'd0);
      chk("d_rst_busy", i, 32'(w_busy[i]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_run();
    chk("d_c0_abcd", 0, 32'(w_abcd[0]), 32'd0);
    chk("d_c0_busy", 0, 32'(w_busy[0]), 32'd1);
    wait_rel(4);
    chk("d_c4_abcd", 0, 32'(w_abcd[0]), 32'b0001);
    chk("d_c4_idx", 0, 32'(w_idx[0]), 32'd1);
    wait_idle(300);
    check_run(64, 64, 16, 16, 32, 16, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
